// File: rtl/pkt_dispatch_module_if.sv
// Packet word stream in, four per-class FIFO write ports out.
// The slave side is the dispatcher. The master side is the upstream parser
// together with the FIFOs.
interface pkt_dispatch_module_if;
   logic          i_pkt_data_wr;
   logic [133:0]  iv_pkt_data;

   logic [6:0]    iv_fnp_fifo_usedw;
   logic [6:0]    iv_lnp_fifo_usedw;
   logic [6:0]    iv_mux2fifo_usedw;
   logic [6:0]    iv_srm2fifo_usedw;

   logic          o_fnp_fifo_wr;
   logic          o_lnp_fifo_wr;
   logic          o_mux2fifo_wr;
   logic          o_srm2fifo_wr;

   logic [133:0]  ov_fnp_fifo_data;
   logic [133:0]  ov_lnp_fifo_data;
   logic [133:0]  ov_mux2fifo_data;
   logic [133:0]  ov_srm2fifo_data;

   modport slave (
      input  i_pkt_data_wr, iv_pkt_data,
      input  iv_fnp_fifo_usedw, iv_lnp_fifo_usedw, iv_mux2fifo_usedw, iv_srm2fifo_usedw,
      output o_fnp_fifo_wr, o_lnp_fifo_wr, o_mux2fifo_wr, o_srm2fifo_wr,
      output ov_fnp_fifo_data, ov_lnp_fifo_data, ov_mux2fifo_data, ov_srm2fifo_data
   );

   modport master (
      output i_pkt_data_wr, iv_pkt_data,
      output iv_fnp_fifo_usedw, iv_lnp_fifo_usedw, iv_mux2fifo_usedw, iv_srm2fifo_usedw,
      input  o_fnp_fifo_wr, o_lnp_fifo_wr, o_mux2fifo_wr, o_srm2fifo_wr,
      input  ov_fnp_fifo_data, ov_lnp_fifo_data, ov_mux2fifo_data, ov_srm2fifo_data
   );
endinterface

// File: rtl/pkt_dispatch_module.sv
// Packet dispatcher: steers whole packets into the fnp/lnp/mux2fifo/srm2fifo
// FIFOs. A packet is admitted only while its target FIFO has room for a
// maximum-length packet. Every packet written to a FIFO is closed with a
// tail word, so the reader side, which reads until it sees a tail, never stalls.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for a head; non-head words are ignored
//   FWD     | forwarding the admitted packet to the FIFO latched in dest_q
//   DISCARD | dropping words until a tail; a head is re-checked for admission
module pkt_dispatch_module #(
   parameter int         MAX_PKT_WORDS = 64,
   parameter logic [6:0] ADMIT_TH      = 7'd63
) (
   input  logic                 clk,
   input  logic                 rst,
   pkt_dispatch_module_if.slave bus,
   output logic [15:0]          ov_drop_pkt_cnt,
   output logic [15:0]          ov_err_cnt
);

   typedef enum logic [1:0] {IDLE, FWD, DISCARD} state_t;

   localparam logic [1:0] T_INV  = 2'b00;
   localparam logic [1:0] T_HEAD = 2'b01;
   localparam logic [1:0] T_TAIL = 2'b10;
   localparam logic [1:0] T_BODY = 2'b11;
   localparam logic [6:0] MAX_W  = 7'(MAX_PKT_WORDS);

   state_t        state_q, state_d;
   logic [6:0]    wcnt_q, wcnt_d;
   logic [1:0]    dest_q, dest_d;
   logic [15:0]   drop_q, drop_d;
   logic [15:0]   err_q, err_d;
   logic [3:0]    wr_q;
   logic [133:0]  data_q [4];

   logic          wr_en_d;
   logic [1:0]    wr_sel_d;
   logic [133:0]  wr_word_d;

   logic [1:0]    word_type;
   logic [1:0]    head_cls;
   logic [6:0]    head_usedw;
   logic          admit;
   logic [133:0]  tailed_word;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Decode the incoming word and pick the usedw of the class named in a head.
   always_comb begin
      word_type   = bus.iv_pkt_data[133:132];
      head_cls    = bus.iv_pkt_data[127:126];
      tailed_word = {T_TAIL, bus.iv_pkt_data[131:0]};
      case (head_cls)
         2'b00:   head_usedw = bus.iv_fnp_fifo_usedw;
         2'b01:   head_usedw = bus.iv_lnp_fifo_usedw;
         2'b10:   head_usedw = bus.iv_mux2fifo_usedw;
         default: head_usedw = bus.iv_srm2fifo_usedw;
      endcase
      admit = (head_usedw <= ADMIT_TH);
   end

   // Next-state, counter and write-request logic for one input word.
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      dest_d    = dest_q;
      drop_d    = drop_q;
      err_d     = err_q;
      wr_en_d   = 1'b0;
      wr_sel_d  = dest_q;
      wr_word_d = bus.iv_pkt_data;

      if (bus.i_pkt_data_wr) begin
         case (state_q)
            FWD: begin
               case (word_type)
                  T_BODY: begin
                     wr_en_d = 1'b1;
                     // The word that reaches the length limit becomes the
                     // tail, so the FIFO never holds an unterminated packet.
                     if (wcnt_q + 7'd1 == MAX_W) begin
                        wr_word_d = tailed_word;
                        err_d     = sat_inc(err_q);
                        wcnt_d    = 7'd0;
                        state_d   = DISCARD;
                     end else begin
                        wcnt_d = wcnt_q + 7'd1;
                     end
                  end
                  T_TAIL: begin
                     wr_en_d = 1'b1;
                     wcnt_d  = 7'd0;
                     state_d = IDLE;
                  end
                  T_HEAD: begin
                     // A missing tail: close the current packet with this
                     // word and skip the new packet entirely.
                     wr_en_d   = 1'b1;
                     wr_word_d = tailed_word;
                     err_d     = sat_inc(err_q);
                     wcnt_d    = 7'd0;
                     state_d   = DISCARD;
                  end
                  default: begin
                     err_d = sat_inc(err_q);
                  end
               endcase
            end
            default: begin
               if (word_type == T_HEAD) begin
                  dest_d = head_cls;
                  if (admit) begin
                     wr_en_d  = 1'b1;
                     wr_sel_d = head_cls;
                     wcnt_d   = 7'd1;
                     state_d  = FWD;
                  end else begin
                     drop_d  = sat_inc(drop_q);
                     wcnt_d  = 7'd0;
                     state_d = DISCARD;
                  end
               end else if (state_q == DISCARD && word_type == T_TAIL) begin
                  state_d = IDLE;
               end
            end
         endcase
      end
   end

   // State, counters and registered FIFO write ports.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wcnt_q  <= 7'd0;
         dest_q  <= 2'b00;
         drop_q  <= 16'd0;
         err_q   <= 16'd0;
         wr_q    <= 4'b0000;
         for (int i = 0; i < 4; i++) data_q[i] <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         dest_q  <= dest_d;
         drop_q  <= drop_d;
         err_q   <= err_d;
         wr_q    <= 4'b0000;
         if (wr_en_d) begin
            wr_q[wr_sel_d]   <= 1'b1;
            data_q[wr_sel_d] <= wr_word_d;
         end
      end
   end

   assign bus.o_fnp_fifo_wr    = wr_q[0];
   assign bus.o_lnp_fifo_wr    = wr_q[1];
   assign bus.o_mux2fifo_wr    = wr_q[2];
   assign bus.o_srm2fifo_wr    = wr_q[3];
   assign bus.ov_fnp_fifo_data = data_q[0];
   assign bus.ov_lnp_fifo_data = data_q[1];
   assign bus.ov_mux2fifo_data = data_q[2];
   assign bus.ov_srm2fifo_data = data_q[3];
   assign ov_drop_pkt_cnt      = drop_q;
   assign ov_err_cnt           = err_q;

endmodule

// File: tb/tb_pkt_dispatch_module.sv
// Directed bench for pkt_dispatch_module: every FIFO write is logged at the
// falling edge and compared against hand-built expected word lists.
module tb_pkt_dispatch_module;

   localparam logic [1:0] T_INV  = 2'b00;
   localparam logic [1:0] T_HEAD = 2'b01;
   localparam logic [1:0] T_TAIL = 2'b10;
   localparam logic [1:0] T_BODY = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] drop_cnt;
   logic [15:0] err_cnt;

   always #5 clk = ~clk;

   pkt_dispatch_module_if bus ();

   pkt_dispatch_module #(.MAX_PKT_WORDS(64), .ADMIT_TH(7'd63)) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .ov_drop_pkt_cnt (drop_cnt),
      .ov_err_cnt      (err_cnt)
   );

   typedef struct {
      int           fifo;
      logic [133:0] d;
      int           cyc;
   } wr_t;

   wr_t  log_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   t_start;
   logic [3:0] mon_s;

   task automatic check_val(input string tag, input logic [133:0] obs, input logic [133:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [133:0] mk(input logic [1:0] t, input logic [1:0] c, input logic [31:0] tag);
      return {t, 4'h0, c, 94'h0, tag};
   endfunction

   task automatic send(input logic [133:0] d);
      @(posedge clk);
      #1;
      bus.i_pkt_data_wr = 1'b1;
      bus.iv_pkt_data   = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         bus.i_pkt_data_wr = 1'b0;
         bus.iv_pkt_data   = '0;
      end
   endtask

   task automatic expect_wr(input string tag, input int idx, input int fifo, input logic [133:0] d);
      if (idx < log_q.size()) begin
         check_val({tag, "_fifo"}, log_q[idx].fifo, fifo);
         check_val({tag, "_data"}, log_q[idx].d, d);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      mon_s = {bus.o_srm2fifo_wr, bus.o_mux2fifo_wr, bus.o_lnp_fifo_wr, bus.o_fnp_fifo_wr};
      if (mon_s != 4'b0000) begin
         check_val("one_strobe", $countones(mon_s), 1);
         if (mon_s[0]) log_q.push_back('{0, bus.ov_fnp_fifo_data, cyc});
         if (mon_s[1]) log_q.push_back('{1, bus.ov_lnp_fifo_data, cyc});
         if (mon_s[2]) log_q.push_back('{2, bus.ov_mux2fifo_data, cyc});
         if (mon_s[3]) log_q.push_back('{3, bus.ov_srm2fifo_data, cyc});
      end
   end

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_fnp_wr"}, bus.o_fnp_fifo_wr, 0);
      check_val({tag, "_lnp_wr"}, bus.o_lnp_fifo_wr, 0);
      check_val({tag, "_mux_wr"}, bus.o_mux2fifo_wr, 0);
      check_val({tag, "_srm_wr"}, bus.o_srm2fifo_wr, 0);
      check_val({tag, "_fnp_d"}, bus.ov_fnp_fifo_data, 0);
      check_val({tag, "_lnp_d"}, bus.ov_lnp_fifo_data, 0);
      check_val({tag, "_mux_d"}, bus.ov_mux2fifo_data, 0);
      check_val({tag, "_srm_d"}, bus.ov_srm2fifo_data, 0);
      check_val({tag, "_drop"}, drop_cnt, 0);
      check_val({tag, "_err"}, err_cnt, 0);
   endtask

   initial begin
      bus.i_pkt_data_wr     = 1'b0;
      bus.iv_pkt_data       = '0;
      bus.iv_fnp_fifo_usedw = 7'd0;
      bus.iv_lnp_fifo_usedw = 7'd0;
      bus.iv_mux2fifo_usedw = 7'd0;
      bus.iv_srm2fifo_usedw = 7'd0;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      idle(2);

      // 4-word fnp packet, one-cycle latency, no gaps
      log_q.delete();
      send(mk(T_HEAD, 2'b00, 32'h11));
      t_start = cyc;
      send(mk(T_BODY, 2'b00, 32'h12));
      send(mk(T_BODY, 2'b00, 32'h13));
      send(mk(T_TAIL, 2'b00, 32'h14));
      idle(3);
      check_val("t1_count", log_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         expect_wr("t1", i, 0, mk((i == 0) ? T_HEAD : (i == 3) ? T_TAIL : T_BODY, 2'b00, 32'h11 + i));
         if (i < log_q.size()) check_val("t1_cyc", log_q[i].cyc, t_start + 1 + i);
      end
      check_val("t1_hold_wr", bus.o_fnp_fifo_wr, 0);
      check_val("t1_hold_d", bus.ov_fnp_fifo_data, mk(T_TAIL, 2'b00, 32'h14));

      // four back-to-back 2-word packets, one per class
      log_q.delete();
      for (int c = 0; c < 4; c++) begin
         send(mk(T_HEAD, 2'(c), 32'h100 + 2 * c));
         if (c == 0) t_start = cyc;
         send(mk(T_TAIL, 2'(c), 32'h101 + 2 * c));
      end
      idle(3);
      check_val("t2_count", log_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         expect_wr("t2", i, i / 2, mk((i % 2 == 0) ? T_HEAD : T_TAIL, 2'(i / 2), 32'h100 + i));
         if (i < log_q.size()) check_val("t2_cyc", log_q[i].cyc, t_start + 1 + i);
      end

      // admission refused at usedw 64, accepted at 63
      log_q.delete();
      bus.iv_lnp_fifo_usedw = 7'd64;
      send(mk(T_HEAD, 2'b01, 32'h200));
      send(mk(T_BODY, 2'b01, 32'h201));
      send(mk(T_TAIL, 2'b01, 32'h202));
      idle(3);
      check_val("t3_drop_count", log_q.size(), 0);
      check_val("t3_drop_cnt", drop_cnt, 1);
      check_val("t3_err_cnt", err_cnt, 0);
      bus.iv_lnp_fifo_usedw = 7'd63;
      send(mk(T_HEAD, 2'b01, 32'h210));
      send(mk(T_BODY, 2'b01, 32'h211));
      send(mk(T_TAIL, 2'b01, 32'h212));
      idle(3);
      check_val("t3_adm_count", log_q.size(), 3);
      expect_wr("t3_h", 0, 1, mk(T_HEAD, 2'b01, 32'h210));
      expect_wr("t3_b", 1, 1, mk(T_BODY, 2'b01, 32'h211));
      expect_wr("t3_t", 2, 1, mk(T_TAIL, 2'b01, 32'h212));
      check_val("t3_drop_cnt2", drop_cnt, 1);

      // 70-word packet truncated at 64 words, then a normal packet
      log_q.delete();
      for (int i = 1; i <= 70; i++)
         send(mk((i == 1) ? T_HEAD : (i == 70) ? T_TAIL : T_BODY, 2'b00, 32'(i)));
      send(mk(T_HEAD, 2'b10, 32'h300));
      send(mk(T_TAIL, 2'b10, 32'h301));
      idle(3);
      check_val("t4_count", log_q.size(), 66);
      expect_wr("t4_w1", 0, 0, mk(T_HEAD, 2'b00, 32'd1));
      expect_wr("t4_w63", 62, 0, mk(T_BODY, 2'b00, 32'd63));
      expect_wr("t4_w64", 63, 0, mk(T_TAIL, 2'b00, 32'd64));
      expect_wr("t4_nh", 64, 2, mk(T_HEAD, 2'b10, 32'h300));
      expect_wr("t4_nt", 65, 2, mk(T_TAIL, 2'b10, 32'h301));
      check_val("t4_err_cnt", err_cnt, 1);

      // missing tail: new head closes the srm packet, its packet is skipped
      log_q.delete();
      send(mk(T_HEAD, 2'b11, 32'h400));
      send(mk(T_BODY, 2'b11, 32'h401));
      send(mk(T_HEAD, 2'b10, 32'h402));
      send(mk(T_BODY, 2'b10, 32'h403));
      send(mk(T_TAIL, 2'b10, 32'h404));
      idle(2);
      check_val("t5_count_a", log_q.size(), 3);
      check_val("t5_err_cnt", err_cnt, 2);
      check_val("t5_srm_hold", bus.ov_srm2fifo_data, mk(T_TAIL, 2'b10, 32'h402));
      send(mk(T_HEAD, 2'b10, 32'h410));
      send(mk(T_TAIL, 2'b10, 32'h411));
      idle(3);
      check_val("t5_count_b", log_q.size(), 5);
      expect_wr("t5_h", 0, 3, mk(T_HEAD, 2'b11, 32'h400));
      expect_wr("t5_b", 1, 3, mk(T_BODY, 2'b11, 32'h401));
      expect_wr("t5_x", 2, 3, mk(T_TAIL, 2'b10, 32'h402));
      expect_wr("t5_nh", 3, 2, mk(T_HEAD, 2'b10, 32'h410));
      expect_wr("t5_nt", 4, 2, mk(T_TAIL, 2'b10, 32'h411));

      // reset mid-packet
      log_q.delete();
      send(mk(T_HEAD, 2'b01, 32'h500));
      send(mk(T_BODY, 2'b01, 32'h501));
      idle(1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_outputs_zero("t6_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(mk(T_BODY, 2'b01, 32'h502));
      send(mk(T_BODY, 2'b01, 32'h503));
      send(mk(T_TAIL, 2'b01, 32'h504));
      send(mk(T_HEAD, 2'b01, 32'h510));
      send(mk(T_TAIL, 2'b01, 32'h511));
      idle(3);
      check_val("t6_count", log_q.size(), 4);
      expect_wr("t6_h", 0, 1, mk(T_HEAD, 2'b01, 32'h500));
      expect_wr("t6_b", 1, 1, mk(T_BODY, 2'b01, 32'h501));
      expect_wr("t6_nh", 2, 1, mk(T_HEAD, 2'b01, 32'h510));
      expect_wr("t6_nt", 3, 1, mk(T_TAIL, 2'b01, 32'h511));
      check_val("t6_err_cnt", err_cnt, 0);

      // stray words in IDLE, then an invalid word inside a packet
      log_q.delete();
      send(mk(T_BODY, 2'b00, 32'h600));
      send(mk(T_TAIL, 2'b00, 32'h601));
      send(mk(T_INV, 2'b00, 32'h602));
      idle(2);
      check_val("t7_idle_count", log_q.size(), 0);
      check_val("t7_idle_err", err_cnt, 0);
      check_val("t7_idle_drop", drop_cnt, 0);
      send(mk(T_HEAD, 2'b00, 32'h610));
      send(mk(T_INV, 2'b00, 32'h611));
      send(mk(T_BODY, 2'b00, 32'h612));
      send(mk(T_TAIL, 2'b00, 32'h613));
      idle(3);
      check_val("t7_count", log_q.size(), 3);
      expect_wr("t7_h", 0, 0, mk(T_HEAD, 2'b00, 32'h610));
      expect_wr("t7_b", 1, 0, mk(T_BODY, 2'b00, 32'h612));
      expect_wr("t7_t", 2, 0, mk(T_TAIL, 2'b00, 32'h613));
      check_val("t7_err_cnt", err_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
